// File: rtl/async_handshake_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : async_handshake_rx_fifo
// Description : Receiver side of a 4-phase rqst/ack bus handshake. Captures
//               BusData once per handshake into a DEPTH-entry FIFO that
//               local logic drains through valid/ready. ack is withheld
//               while the FIFO is full, so no word is ever dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module async_handshake_rx_fifo #(
  parameter int B           = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rqst,
  input  logic [B-1:0]               BusData,
  input  logic                       en,
  output logic                       ack,
  output logic [B-1:0]               dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rqst_s;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_ack;
  logic                   w_ack_nxt;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic [B-1:0]           r_mem [DEPTH];
  logic [c_PTR_W-1:0]     r_wptr;
  logic [c_PTR_W-1:0]     r_rptr;
  logic [c_CNT_W-1:0]     r_count;

  // Bring the asynchronous request into the clk domain through a flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rqst};
    end
  end

  assign w_rqst_s = r_sync[SYNC_STAGES-1];
  // Full looks at the occupancy before this edge; a simultaneous pop does not free room yet.
  assign w_full   = (r_count == c_CNT_FULL);

  // Handshake state and the registered acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Next state: accept only from IDLE; once acknowledged, wait for the request to fall.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ack_nxt = 1'b0;
        if (w_rqst_s && en && !w_full) begin
          w_push      = 1'b1;
          w_state_nxt = S_ACK;
          w_ack_nxt   = 1'b1;
        end
      end
      S_ACK: begin
        w_ack_nxt = 1'b1;
        if (!w_rqst_s) begin
          w_state_nxt = S_IDLE;
          w_ack_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ack_nxt   = 1'b0;
      end
    endcase
  end

  // Storage: cleared on reset so dout reads zero until the first capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= BusData;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout_valid = (r_count != '0);
  assign w_pop      = dout_valid & dout_ready;
  assign dout       = r_mem[r_rptr];
  assign ack        = r_ack;
  assign count      = r_count;

endmodule
`default_nettype wire
